// File: rtl/pw_phase_shift_if.sv
// Fine phase-shift control bundle between the register block and the MMCM sequencer.
// The slave side belongs to pw_phase_shift; the master side drives targets and MMCM status.
interface pw_phase_shift_if #(
  parameter int pPHASE_WIDTH = 10
) ();
  logic signed [pPHASE_WIDTH-1:0] I_target;
  logic                           I_go;
  logic                           I_locked;
  logic                           I_psdone;
  logic                           O_psen;
  logic                           O_psincdec;
  logic signed [pPHASE_WIDTH-1:0] O_current;
  logic                           O_busy;
  logic                           O_done;
  logic                           O_timeout_err;

  modport master (
    output I_target, I_go, I_locked, I_psdone,
    input  O_psen, O_psincdec, O_current, O_busy, O_done, O_timeout_err
  );

  modport slave (
    input  I_target, I_go, I_locked, I_psdone,
    output O_psen, O_psincdec, O_current, O_busy, O_done, O_timeout_err
  );
endinterface

// File: rtl/pw_phase_shift.sv
// MMCM dynamic fine phase-shift sequencer: walks the applied phase one psen/psdone step at a
// time toward a signed target, tracking lock loss and psdone timeouts.
module pw_phase_shift #(
  parameter int pPHASE_WIDTH = 10,
  parameter int pTIMEOUT     = 63
) (
  input logic             usb_clk,
  input logic             reset_n,
  pw_phase_shift_if.slave bus
);
  localparam int pCNT_WIDTH = $clog2(pTIMEOUT + 1);
  localparam logic [pCNT_WIDTH-1:0] pCNT_LAST = pCNT_WIDTH'(pTIMEOUT - 1);
  localparam logic [pCNT_WIDTH-1:0] pCNT_ONE  = pCNT_WIDTH'(1);
  localparam logic signed [pPHASE_WIDTH-1:0] pPH_MAX = {1'b0, {(pPHASE_WIDTH-1){1'b1}}};
  localparam logic signed [pPHASE_WIDTH-1:0] pPH_MIN = {1'b1, {(pPHASE_WIDTH-1){1'b0}}};
  localparam logic signed [pPHASE_WIDTH-1:0] pPH_ONE = pPHASE_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StWaitLock, StStep, StWaitDone} state_t;

  state_t                         state_q, state_d;
  logic signed [pPHASE_WIDTH-1:0] target_q, target_d;
  logic signed [pPHASE_WIDTH-1:0] current_q, current_d;
  logic signed [pPHASE_WIDTH-1:0] stepped;
  logic [pCNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic psen_q, psen_d;
  logic psincdec_q, psincdec_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  // psincdec_q holds the direction of the step in flight until the next STEP.
  always_comb begin
    if (psincdec_q) begin
      stepped = (current_q == pPH_MAX) ? current_q : current_q + pPH_ONE;
    end else begin
      stepped = (current_q == pPH_MIN) ? current_q : current_q - pPH_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = bus.I_go ? bus.I_target : target_q;
    current_d  = current_q;
    cnt_d      = cnt_q;
    psen_d     = 1'b0;
    psincdec_d = psincdec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = bus.I_go ? 1'b0 : err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.I_go) begin
          if (target_d == current_q) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = StWaitLock;
          end
        end
      end
      StWaitLock: begin
        if (bus.I_locked) begin
          if (target_d != current_q) begin
            state_d = StStep;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StStep: begin
        psen_d     = 1'b1;
        psincdec_d = (target_d > current_q);
        cnt_d      = '0;
        state_d    = StWaitDone;
      end
      StWaitDone: begin
        if (bus.I_psdone) begin
          current_d = stepped;
          if (stepped == target_d) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StWaitLock;
          end
        end else if (cnt_q == pCNT_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + pCNT_ONE;
        end
      end
      default: state_d = StIdle;
    endcase

    // An MMCM reset returns the phase offset to zero; any unacknowledged step is lost.
    if (!bus.I_locked) begin
      current_d = '0;
      if (state_q == StStep || state_q == StWaitDone) begin
        state_d    = StWaitLock;
        psen_d     = 1'b0;
        psincdec_d = psincdec_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        err_d      = bus.I_go ? 1'b0 : err_q;
      end
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      target_q   <= '0;
      current_q  <= '0;
      cnt_q      <= '0;
      psen_q     <= 1'b0;
      psincdec_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      current_q  <= current_d;
      cnt_q      <= cnt_d;
      psen_q     <= psen_d;
      psincdec_q <= psincdec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.O_psen        = psen_q;
  assign bus.O_psincdec    = psincdec_q;
  assign bus.O_current     = current_q;
  assign bus.O_busy        = busy_q;
  assign bus.O_done        = done_q;
  assign bus.O_timeout_err = err_q;
endmodule
